multicycle_sequencer: RTL

Multi-cycle control sequencer for the CPU datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine so instruction fetch and data access can share one memory port. It drives the same datapath control signals as the single-cycle decoder, plus PC/IR write enables. It stalls on a memory-ready handshake.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/wait_timer.sv | 32 +++
 rtl/multicycle_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: sequencer state
// codes, opcode values and ALU operation codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_ADDI = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    // Opcodes 0..7 are register-register ALU operations.
    function automatic logic is_rtype(input logic [3:0] op);
        return ~op[3];
    endfunction

    // Loads and stores are the only instructions that visit MEM.
    function automatic logic is_memop(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Stall counter for the memory handshake. Counts enabled cycles since the
// last clear and flags the cycle in which the MAX_CYCLES-th consecutive
// stall cycle is being spent.
module wait_timer #(
    parameter int MAX_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = $clog2(MAX_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(MAX_CYCLES - 1);

    logic [W-1:0] count_q;

    // Count stall cycles, saturating at the last one so expired stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB over a single
// shared memory port, stalling on mem_ready.
// Optional stall watchdog: define SEQ_WAIT_TIMEOUT_EN to halt with a sticky
// fault after TIMEOUT_CYCLES consecutive stall cycles in FETCH or MEM.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       branch,
    output logic       regdst,
    output logic       alusrc,
    output logic       regwrite,
    output logic       memread,
    output logic       memreg,
    output logic       memwrite,
    output logic [2:0] aluop,
    output logic [2:0] state,
    output logic       retire,
    output logic       halted,
    output logic       fault
);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       timeout;
    logic       fault_q, fault_d;

`ifdef SEQ_WAIT_TIMEOUT_EN
    logic waiting;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign waiting      = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign timer_enable = waiting && !mem_ready;
    assign timer_clear  = !waiting || mem_ready || (state_d != state_q);
    assign timeout      = timer_enable && timer_expired;

    wait_timer #(
        .MAX_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (timer_clear),
        .enable_i (timer_enable),
        .expired_o(timer_expired)
    );
`else
    // Without the watchdog the timeout depth has no effect; keep it referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    // Next-state logic: advance through the instruction phases, stalling in
    // FETCH/MEM until memory is ready and stopping at instruction boundaries.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fault_d = fault_q | timeout;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready)    state_d = ST_DECODE;
                else if (timeout) state_d = ST_HALT;
            end
            ST_DECODE: begin
                op_d    = opcode;
                state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (is_rtype(op_q) || (op_q == OP_ADDI)) state_d = ST_WB;
                else if (is_memop(op_q))                 state_d = ST_MEM;
                else                                     state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LW) state_d = ST_WB;
                    else               state_d = run ? ST_FETCH : ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB:   state_d = run ? ST_FETCH : ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched opcode and sticky fault registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fault_q <= fault_d;
        end
    end

    // Datapath controls decoded from state and latched opcode; PC/IR writes
    // and retire also follow zero/mem_ready where the handshake requires it.
    always_comb begin
        pc_write = 1'b0;
        ir_write = 1'b0;
        branch   = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memreg   = 1'b0;
        memwrite = 1'b0;
        aluop    = ALU_ADD;
        retire   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                memread = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_EXEC: begin
                if (is_rtype(op_q)) begin
                    regdst = 1'b1;
                    aluop  = op_q[2:0];
                end else if ((op_q == OP_ADDI) || is_memop(op_q)) begin
                    alusrc = 1'b1;
                end else if (op_q == OP_BEQ) begin
                    branch   = 1'b1;
                    aluop    = ALU_SUB;
                    pc_write = zero;
                    retire   = 1'b1;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_MEM: begin
                memread  = (op_q == OP_LW);
                memwrite = (op_q == OP_SW);
                retire   = (op_q == OP_SW) && mem_ready;
            end
            ST_WB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                memreg   = (op_q == OP_LW);
                regdst   = is_rtype(op_q);
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule
